// File: rtl/useq_fetch.sv
// Microprogram sequencer with ROM address generation, pipeline register,
// 4-deep subroutine stack and a loop counter.
module useq_fetch #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              en_,
  input  logic [2:0]        i,
  input  logic [HEIGHT-1:0] d,
  input  logic              cc_,
  input  logic [WIDTH-1:0]  rd,
  output logic [HEIGHT-1:0] a,
  output logic              cs_,
  output logic [WIDTH-1:0]  pl,
  output logic              full_,
  output logic              empty_
);

  typedef logic [HEIGHT-1:0] addr_t;

  typedef enum logic [2:0] {
    OP_JZ   = 3'd0,
    OP_CONT = 3'd1,
    OP_CJP  = 3'd2,
    OP_CJS  = 3'd3,
    OP_CRTN = 3'd4,
    OP_LDCT = 3'd5,
    OP_RPCT = 3'd6,
    OP_CJPP = 3'd7
  } op_t;

  addr_t            upc_reg, upc_next;
  addr_t            ctr_reg, ctr_next;
  logic [2:0]       sp_reg, sp_next;
  addr_t            stack_reg [4];
  logic             run_reg;
  logic [WIDTH-1:0] pl_reg;

  op_t        op;
  logic       advance;
  logic       push, pop, clear_sp;
  addr_t      inc, top;
  logic [1:0] top_idx, push_idx;

  assign op      = op_t'(i);
  assign advance = run_reg & ~en_;
  assign inc     = upc_reg + addr_t'(1);

  // sp counts 0..4; the low two bits minus one address the top entry.
  assign top_idx  = sp_reg[1:0] - 2'd1;
  assign top      = (sp_reg == 3'd0) ? '0 : stack_reg[top_idx];
  // A push on a full stack overwrites the top entry in place.
  assign push_idx = (sp_reg == 3'd4) ? 2'd3 : sp_reg[1:0];

  always_comb begin
    upc_next = inc;
    ctr_next = ctr_reg;
    push     = 1'b0;
    pop      = 1'b0;
    clear_sp = 1'b0;
    case (op)
      OP_JZ: begin
        upc_next = '0;
        clear_sp = 1'b1;
      end
      OP_CONT: ;
      OP_CJP: if (!cc_) upc_next = d;
      OP_CJS: if (!cc_) begin
        push     = 1'b1;
        upc_next = d;
      end
      OP_CRTN: if (!cc_) begin
        pop      = 1'b1;
        upc_next = top;
      end
      OP_LDCT: ctr_next = d;
      OP_RPCT: if (ctr_reg != '0) begin
        ctr_next = ctr_reg - addr_t'(1);
        upc_next = d;
      end
      OP_CJPP: if (!cc_) begin
        pop      = 1'b1;
        upc_next = d;
      end
      default: ;
    endcase
  end

  always_comb begin
    sp_next = sp_reg;
    if (clear_sp)
      sp_next = 3'd0;
    else if (push && sp_reg != 3'd4)
      sp_next = sp_reg + 3'd1;
    else if (pop && sp_reg != 3'd0)
      sp_next = sp_reg - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      upc_reg <= '0;
      ctr_reg <= '0;
      sp_reg  <= 3'd0;
      pl_reg  <= '0;
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (advance) begin
        upc_reg <= upc_next;
        ctr_reg <= ctr_next;
        sp_reg  <= sp_next;
        pl_reg  <= rd;
      end
    end
  end

  // Stack contents need no reset: sp=0 makes every entry unreachable.
  always_ff @(posedge clk) begin
    if (rst_ && advance && push)
      stack_reg[push_idx] <= inc;
  end

  assign a      = upc_reg;
  assign cs_    = ~run_reg;
  assign pl     = pl_reg;
  assign full_  = (sp_reg != 3'd4);
  assign empty_ = (sp_reg != 3'd0);

endmodule

// File: tb/tb_useq_fetch.sv
// Directed bench for useq_fetch: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_useq_fetch;

  logic        clk = 1'b0;
  logic        rst_;
  logic        en_;
  logic [2:0]  i;
  logic [7:0]  d;
  logic        cc_;
  logic [15:0] rd;
  logic [7:0]  a;
  logic        cs_;
  logic [15:0] pl;
  logic        full_;
  logic        empty_;

  useq_fetch #(.WIDTH(16), .HEIGHT(8)) dut (
    .clk    (clk),
    .rst_   (rst_),
    .en_    (en_),
    .i      (i),
    .d      (d),
    .cc_    (cc_),
    .rd     (rd),
    .a      (a),
    .cs_    (cs_),
    .pl     (pl),
    .full_  (full_),
    .empty_ (empty_)
  );

  always #5 clk = ~clk;

  // ROM image: word n holds n + 0x100.
  assign rd = 16'h0100 + {8'h00, a};

  typedef struct {
    string       name;
    logic [7:0]  a;
    logic [15:0] pl;
    logic        cs;
    logic        full;
    logic        empty;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model of the visible pipeline: run flag, last address, pl.
  logic        run_m = 1'b0;
  logic [7:0]  a_m   = 8'h00;
  logic [15:0] pl_m  = 16'h0000;

  localparam logic [2:0] JZ = 3'd0, CONT = 3'd1, CJP = 3'd2, CJS = 3'd3,
                         CRTN = 3'd4, LDCT = 3'd5, RPCT = 3'd6, CJPP = 3'd7;

  task automatic step(input string name, input logic r, input logic e,
                      input logic [2:0] op, input logic [7:0] dv, input logic c,
                      input logic [7:0] exp_a, input int exp_sp);
    exp_t x;
    rst_ = r;
    en_  = e;
    i    = op;
    d    = dv;
    cc_  = c;
    if (!r) begin
      run_m = 1'b0;
      pl_m  = 16'h0000;
    end else if (run_m && !e) begin
      pl_m  = 16'h0100 + {8'h00, a_m};
    end else begin
      run_m = 1'b1;
    end
    a_m     = exp_a;
    x.name  = name;
    x.a     = exp_a;
    x.pl    = pl_m;
    x.cs    = ~run_m;
    x.full  = (exp_sp != 4);
    x.empty = (exp_sp != 0);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (a !== x.a || pl !== x.pl || cs_ !== x.cs ||
            full_ !== x.full || empty_ !== x.empty) begin
          errors++;
          $display("FAIL %s: got a=%h pl=%h cs_=%b full_=%b empty_=%b, want a=%h pl=%h cs_=%b full_=%b empty_=%b",
                   x.name, a, pl, cs_, full_, empty_, x.a, x.pl, x.cs, x.full, x.empty);
        end else begin
          $display("txn %s a=%h pl=%h cs_=%b full_=%b empty_=%b",
                   x.name, a, pl, cs_, full_, empty_);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_ = 1'b0; en_ = 1'b1; i = CONT; d = 8'h00; cc_ = 1'b1;
    #2;
    // Reset, including priority over an enabled taken branch.
    step("rst0",      0, 1, CONT, 8'h00, 1, 8'h00, 0);
    step("rst_prio",  0, 0, CJP,  8'h55, 0, 8'h00, 0);
    // Run-up and straight-line fetch.
    step("run_set",   1, 0, CONT, 8'h00, 1, 8'h00, 0);
    step("cont1",     1, 0, CONT, 8'h00, 1, 8'h01, 0);
    step("cont2",     1, 0, CONT, 8'h00, 1, 8'h02, 0);
    step("cont3",     1, 0, CONT, 8'h00, 1, 8'h03, 0);
    // Subroutine call / return.
    step("cjp_10",    1, 0, CJP,  8'h10, 0, 8'h10, 0);
    step("cjs_40",    1, 0, CJS,  8'h40, 0, 8'h40, 1);
    step("crtn_11",   1, 0, CRTN, 8'h77, 0, 8'h11, 0);
    step("crtn_fail", 1, 0, CRTN, 8'h77, 1, 8'h12, 0);
    step("cjp_fail",  1, 0, CJP,  8'h77, 1, 8'h13, 0);
    step("cjs_fail",  1, 0, CJS,  8'h77, 1, 8'h14, 0);
    // Loop counter: body at 0x21 runs 4 times.
    step("cjp_20",    1, 0, CJP,  8'h20, 0, 8'h20, 0);
    step("ldct_3",    1, 0, LDCT, 8'h03, 1, 8'h21, 0);
    step("rpct_a",    1, 0, RPCT, 8'h21, 1, 8'h21, 0);
    step("rpct_b",    1, 0, RPCT, 8'h21, 1, 8'h21, 0);
    step("rpct_c",    1, 0, RPCT, 8'h21, 1, 8'h21, 0);
    step("rpct_exit", 1, 0, RPCT, 8'h21, 1, 8'h22, 0);
    step("rpct_zero", 1, 0, RPCT, 8'h50, 1, 8'h23, 0);
    // Stack overflow and underflow.
    step("cjp_10b",   1, 0, CJP,  8'h10, 0, 8'h10, 0);
    step("push1",     1, 0, CJS,  8'h11, 0, 8'h11, 1);
    step("push2",     1, 0, CJS,  8'h12, 0, 8'h12, 2);
    step("push3",     1, 0, CJS,  8'h13, 0, 8'h13, 3);
    step("push4",     1, 0, CJS,  8'h14, 0, 8'h14, 4);
    step("push5_ovr", 1, 0, CJS,  8'h15, 0, 8'h15, 4);
    step("pop_15",    1, 0, CRTN, 8'h00, 0, 8'h15, 3);
    step("pop_13",    1, 0, CRTN, 8'h00, 0, 8'h13, 2);
    step("pop_12",    1, 0, CRTN, 8'h00, 0, 8'h12, 1);
    step("pop_11",    1, 0, CRTN, 8'h00, 0, 8'h11, 0);
    step("pop_empty", 1, 0, CRTN, 8'h00, 0, 8'h00, 0);
    // CJPP and JZ stack handling.
    step("cjs_30",    1, 0, CJS,  8'h30, 0, 8'h30, 1);
    step("cjpp_fail", 1, 0, CJPP, 8'h40, 1, 8'h31, 1);
    step("cjpp_40",   1, 0, CJPP, 8'h40, 0, 8'h40, 0);
    step("cjpp_empt", 1, 0, CJPP, 8'h50, 0, 8'h50, 0);
    step("cjs_60",    1, 0, CJS,  8'h60, 0, 8'h60, 1);
    step("jz",        1, 0, JZ,   8'h77, 0, 8'h00, 0);
    // Address wrap and stall with counter/stack live.
    step("ldct_2",    1, 0, LDCT, 8'h02, 1, 8'h01, 0);
    step("cjs_ff",    1, 0, CJS,  8'hFF, 0, 8'hFF, 1);
    step("wrap",      1, 0, CONT, 8'h00, 1, 8'h00, 1);
    step("stall1",    1, 1, CJP,  8'h77, 0, 8'h00, 1);
    step("stall2",    1, 1, CJP,  8'h77, 0, 8'h00, 1);
    step("stall3",    1, 1, CJP,  8'h77, 0, 8'h00, 1);
    step("rpct_2",    1, 0, RPCT, 8'h00, 1, 8'h00, 1);
    step("rpct_1",    1, 0, RPCT, 8'h00, 1, 8'h00, 1);
    step("rpct_0",    1, 0, RPCT, 8'h00, 1, 8'h01, 1);
    step("crtn_02",   1, 0, CRTN, 8'h00, 0, 8'h02, 0);
    // Mid-operation reset discards stack and counter.
    step("ldct_5",    1, 0, LDCT, 8'h05, 1, 8'h03, 0);
    step("cjs_10c",   1, 0, CJS,  8'h10, 0, 8'h10, 1);
    step("cjs_20c",   1, 0, CJS,  8'h20, 0, 8'h20, 2);
    step("rst_mid",   0, 0, CJS,  8'h99, 0, 8'h00, 0);
    step("rerun",     1, 0, CONT, 8'h00, 1, 8'h00, 0);
    step("rpct_ctr0", 1, 0, RPCT, 8'h40, 1, 8'h01, 0);
    step("crtn_emp2", 1, 0, CRTN, 8'h00, 0, 8'h00, 0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
